// File: rtl/mem_responder_pkg.sv
// Shared types and default sizing for the main-memory responder.
package mem_responder_pkg;

    localparam int DEF_ADDR_W   = 10;
    localparam int DEF_DATA_W   = 32;
    localparam int DEF_RD_LAT   = 2;
    localparam int DEF_WR_LAT   = 3;
    localparam int DEF_WB_DEPTH = 4;

    typedef enum logic [1:0] {
        R_IDLE = 2'd0,
        R_WAIT = 2'd1,
        R_DONE = 2'd2
    } rd_state_e;

    typedef struct packed {
        logic [DEF_ADDR_W-1:0] addr;
        logic [DEF_DATA_W-1:0] data;
    } wb_entry_t;

endpackage

// File: rtl/mem_write_buffer.sv
// Write-through FIFO with youngest-match address lookup so reads can forward
// data that has not yet drained into the array.
module mem_write_buffer
    import mem_responder_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W,
    parameter int DEPTH  = DEF_WB_DEPTH
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  logic              pop,
    input  logic [ADDR_W-1:0] in_addr,
    input  logic [DATA_W-1:0] in_data,
    input  logic [ADDR_W-1:0] lookup_addr,
    output logic              hit,
    output logic [DATA_W-1:0] hit_data,
    output logic [ADDR_W-1:0] head_addr,
    output logic [DATA_W-1:0] head_data,
    output logic              full,
    output logic              empty
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [ADDR_W-1:0] addr_q [DEPTH];
    logic [ADDR_W-1:0] addr_d [DEPTH];
    logic [DATA_W-1:0] data_q [DEPTH];
    logic [DATA_W-1:0] data_d [DEPTH];
    logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]     count_q, count_d;
    logic              do_push;
    logic              do_pop;
    logic [PW-1:0]     idx;

    assign full      = (count_q == CW'(DEPTH));
    assign empty     = (count_q == '0);
    assign head_addr = addr_q[rd_ptr_q];
    assign head_data = data_q[rd_ptr_q];
    assign do_push   = push && !full;
    assign do_pop    = pop && !empty;

    always_comb begin
        addr_d   = addr_q;
        data_d   = data_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            addr_d[wr_ptr_q] = in_addr;
            data_d[wr_ptr_q] = in_data;
            wr_ptr_d         = wr_ptr_q + PW'(1);
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end
        if (do_push && !do_pop) begin
            count_d = count_q + CW'(1);
        end else if (do_pop && !do_push) begin
            count_d = count_q - CW'(1);
        end
    end

    // Walk oldest to youngest so the last valid match wins.
    always_comb begin
        hit      = 1'b0;
        hit_data = '0;
        idx      = '0;
        for (int i = 0; i < DEPTH; i++) begin
            idx = rd_ptr_q + PW'(i);
            if ((CW'(i) < count_q) && (addr_q[idx] == lookup_addr)) begin
                hit      = 1'b1;
                hit_data = data_q[idx];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                addr_q[i] <= '0;
                data_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            addr_q   <= addr_d;
            data_q   <= data_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/mem_responder.sv
// Main-memory responder: fixed-latency reads with write-buffer forwarding,
// write-through buffer draining into a single-ported word array.
//
// state  | meaning
// R_IDLE | waiting for a read strobe
// R_WAIT | read captured, latency counter running
// R_DONE | rvalid pulse with the captured word
module mem_responder
    import mem_responder_pkg::*;
#(
    parameter int ADDR_W   = DEF_ADDR_W,
    parameter int DATA_W   = DEF_DATA_W,
    parameter int RD_LAT   = DEF_RD_LAT,
    parameter int WR_LAT   = DEF_WR_LAT,
    parameter int WB_DEPTH = DEF_WB_DEPTH
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              Read_mem,
    input  logic              Write_mem,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata,
    output logic              rvalid,
    output logic              busy,
    output logic              wbuf_full,
    output logic              wbuf_empty,
    output logic              overflow
);

    localparam int LCW = $clog2(RD_LAT + 1);
    localparam int DCW = (WR_LAT > 1) ? $clog2(WR_LAT) : 1;

    logic [DATA_W-1:0] mem_q [2**ADDR_W];

    rd_state_e         state_q, state_d;
    logic [LCW-1:0]    lat_cnt_q, lat_cnt_d;
    logic [DATA_W-1:0] pipe_q, pipe_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              rvalid_q, rvalid_d;
    logic              busy_q, busy_d;
    logic              overflow_q, overflow_d;
    logic [DCW-1:0]    drain_cnt_q, drain_cnt_d;

    logic              rd_accept;
    logic              push;
    logic              commit;
    logic              wb_hit;
    logic [DATA_W-1:0] wb_hit_data;
    logic [ADDR_W-1:0] head_addr;
    logic [DATA_W-1:0] head_data;
    logic [DATA_W-1:0] rd_word;

    // A simultaneous write strobe wins; the cache never issues both.
    assign rd_accept = (state_q == R_IDLE) && Read_mem && !Write_mem;
    assign push      = Write_mem && !wbuf_full;
    assign rd_word   = wb_hit ? wb_hit_data : mem_q[addr];

    mem_write_buffer #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W),
        .DEPTH  (WB_DEPTH)
    ) u_wbuf (
        .clk         (clk),
        .rst         (rst),
        .push        (push),
        .pop         (commit),
        .in_addr     (addr),
        .in_data     (wdata),
        .lookup_addr (addr),
        .hit         (wb_hit),
        .hit_data    (wb_hit_data),
        .head_addr   (head_addr),
        .head_data   (head_data),
        .full        (wbuf_full),
        .empty       (wbuf_empty)
    );

    // The array port belongs to the read on an acceptance edge, so the drain stalls.
    always_comb begin
        drain_cnt_d = drain_cnt_q;
        commit      = 1'b0;
        if (wbuf_empty) begin
            drain_cnt_d = '0;
        end else if (!rd_accept) begin
            if (drain_cnt_q == DCW'(WR_LAT - 1)) begin
                commit      = 1'b1;
                drain_cnt_d = '0;
            end else begin
                drain_cnt_d = drain_cnt_q + DCW'(1);
            end
        end
    end

    assign overflow_d = overflow_q || (Write_mem && wbuf_full);

    always_comb begin
        state_d   = state_q;
        lat_cnt_d = lat_cnt_q;
        pipe_d    = pipe_q;
        rdata_d   = rdata_q;
        rvalid_d  = 1'b0;
        busy_d    = busy_q;
        case (state_q)
            R_IDLE: begin
                if (rd_accept) begin
                    pipe_d    = rd_word;
                    busy_d    = 1'b1;
                    lat_cnt_d = LCW'(1);
                    if (RD_LAT == 1) begin
                        state_d  = R_DONE;
                        rvalid_d = 1'b1;
                        rdata_d  = rd_word;
                    end else begin
                        state_d = R_WAIT;
                    end
                end
            end
            R_WAIT: begin
                if (lat_cnt_q >= LCW'(RD_LAT - 1)) begin
                    state_d  = R_DONE;
                    rvalid_d = 1'b1;
                    rdata_d  = pipe_q;
                end else begin
                    lat_cnt_d = lat_cnt_q + LCW'(1);
                end
            end
            R_DONE: begin
                busy_d  = 1'b0;
                state_d = R_IDLE;
            end
            default: begin
                busy_d  = 1'b0;
                state_d = R_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= R_IDLE;
            lat_cnt_q   <= '0;
            pipe_q      <= '0;
            rdata_q     <= '0;
            rvalid_q    <= 1'b0;
            busy_q      <= 1'b0;
            overflow_q  <= 1'b0;
            drain_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            lat_cnt_q   <= lat_cnt_d;
            pipe_q      <= pipe_d;
            rdata_q     <= rdata_d;
            rvalid_q    <= rvalid_d;
            busy_q      <= busy_d;
            overflow_q  <= overflow_d;
            drain_cnt_q <= drain_cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (commit) begin
            mem_q[head_addr] <= head_data;
        end
    end

    assign rdata    = rdata_q;
    assign rvalid   = rvalid_q;
    assign busy     = busy_q;
    assign overflow = overflow_q;

endmodule

// File: doc/mem_responder.md
Name: mem_responder

Overview:
- Main-memory side of the cache/memory interface. It answers the cache controller's Read_mem and Write_mem strobes.
- Reads are served with a fixed latency that matches the cache refill FSM (request, wait, refill).
- Writes are write-through. They are absorbed by a small write buffer and drained into the word array in the background. Reads forward from the buffer, so they always return the newest data.
- Sits between the cache data path and the backing storage array.

Parameters:
- ADDR_W, 10: word address width; array depth = 2**ADDR_W.
- DATA_W, 32: data word width.
- RD_LAT, 2: cycles from read acceptance to rvalid; must be >= 1.
- WR_LAT, 3: cycles each buffered write occupies before it commits to the array; must be >= 1.
- WB_DEPTH, 4: write-buffer entries; must be a power of 2 and >= 2.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous reset, active-high.
- Read_mem  in  1  read request strobe from the cache.
- Write_mem  in  1  write request strobe from the cache.
- addr  in  ADDR_W  word address for the request.
- wdata  in  DATA_W  write data.
- rdata  out  DATA_W  read data, registered.
- rvalid  out  1  one-cycle pulse; rdata is valid while it is high.
- busy  out  1  a read is in flight.
- wbuf_full  out  1  write buffer holds WB_DEPTH entries.
- wbuf_empty  out  1  write buffer holds no entries.
- overflow  out  1  sticky: a write was dropped because the buffer was full.

Behaviour:
- Reset (asynchronous, active-high):
  - rdata=0, rvalid=0, busy=0, wbuf_full=0, wbuf_empty=1, overflow=0.
  - Read FSM goes to R_IDLE. Buffer pointers, count and drain counter clear; pending writes are lost.
  - Array contents are not reset.
- Read FSM states: R_IDLE, R_WAIT, R_DONE.
  - R_IDLE: on Read_mem=1 and Write_mem=0 at a clock edge, accept the read. Capture the data (source rule below) into an internal pipeline register. busy=1; go to R_WAIT, or straight to R_DONE if RD_LAT=1.
  - R_WAIT: a latency counter counts to RD_LAT-1, then the FSM moves to R_DONE.
  - R_DONE: rvalid=1 and rdata=captured word for exactly one cycle. busy=0. Next state R_IDLE.
  - RD_LAT=2 gives: request in cycle t, rvalid in cycle t+2.
  - rdata holds its last value when rvalid=0.
- Read data source at acceptance:
  - If any valid buffer entry matches addr, use the youngest matching entry.
  - Otherwise use the array word at addr.
- Read_mem asserted while busy=1: ignored. No second rvalid is produced.
- Read_mem and Write_mem both high: treated as a write only; the read is ignored. The cache never issues this combination.
- Write acceptance:
  - Write_mem=1 with wbuf_full=0 pushes {addr, wdata} at the edge.
  - Full is judged on the registered count. A push to a full buffer is refused even if a pop occurs on the same edge.
  - Write_mem=1 with wbuf_full=1: the write is dropped and overflow is set. overflow clears only on rst.
- Drain:
  - While the buffer is non-empty, drain_cnt increments every cycle.
  - On the edge where drain_cnt reaches WR_LAT-1: the head entry is written to the array, the entry is popped, and drain_cnt returns to 0.
  - The array is single-ported. On a read-acceptance edge the drain holds: no commit, and drain_cnt does not increment.
  - Push and pop on the same edge are legal when not full; the count is unchanged.
- Pointers wrap modulo WB_DEPTH. The count is ADDR-independent and $clog2(WB_DEPTH)+1 bits wide.
- wbuf_full and wbuf_empty are decoded from the registered count.

Decomposition:
- Package mem_responder_pkg:
  - read-state encoding (R_IDLE=0, R_WAIT=1, R_DONE=2);
  - default parameter constants;
  - write-buffer entry struct {addr, data}.
- Sub-module mem_write_buffer (FIFO plus associative youngest-match lookup):
  - ports: push, pop, in_addr, in_data, lookup_addr, hit, hit_data, head_addr, head_data, full, empty.
- The array and the read FSM stay in the top module.

Test Plan:
- Basic round trip:
  - Stimulus: write 0x010=0xDEADBEEF; wait until wbuf_empty=1; pulse Read_mem addr 0x010 in cycle t.
  - Required: rvalid=1 only in cycle t+2, rdata=0xDEADBEEF; busy=1 in t+1 and t+2 only.
- Forwarding:
  - Stimulus: back-to-back writes 0x020=0x11111111, then 0x020=0x22222222; Read_mem addr 0x020 in the next cycle.
  - Required: rdata=0x22222222. After the drain finishes, the array holds 0x22222222.
- Overflow (WR_LAT=8):
  - Stimulus: 5 consecutive writes to 0x30..0x34 with data 1..5.
  - Required: wbuf_full=1 after the 4th write; the 5th write is dropped and overflow=1. After the drain, reading 0x34 returns the prior value while 0x30..0x33 return 1..4.
- Read while busy:
  - Stimulus: Read_mem at cycle t and again at cycle t+1.
  - Required: exactly one rvalid, in cycle t+2, carrying the data for the first address.
- Reset mid-read:
  - Stimulus: Read_mem at t; rst asserted during t+1.
  - Required: no rvalid. All outputs go to their reset values immediately, and wbuf_empty=1.
- Simultaneous strobes:
  - Stimulus: Read_mem=1 and Write_mem=1 with addr 0x040, wdata 0xA5A5A5A5.
  - Required: busy stays 0 and no rvalid; the write is buffered (wbuf_empty=0). A later read of 0x040 returns 0xA5A5A5A5.
